uart_tx: RTL

//   8N1 UART transmitter that drives the SOC TXD pin (currently tied to 0).

---
 rtl/uart_tx.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. A one-byte holding register feeds the shift register,
// so a queued byte starts the instant the previous stop bit ends.
module uart_tx #(
    parameter int CLK_FREQ_HZ = 10_000_000,
    parameter int BAUD        = 115200
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       TXD,
    output logic [1:0] state_dbg
);

    // Handshake: a byte transfers on a rising CLK edge where tx_valid && tx_ready;
    // while tx_valid=1 and tx_ready=0 the source keeps tx_data stable and nothing moves.

    localparam int DIV   = CLK_FREQ_HZ / BAUD;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_tx: CLK_FREQ_HZ/BAUD must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             txd_q, txd_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    logic             bit_end;
    logic             load_frame;
    logic             accept;

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        txd_d       = txd_q;
        load_frame  = 1'b0;
        bit_end     = (baud_q == BAUD_LAST);
        baud_d      = bit_end ? '0 : baud_q + 1'b1;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                txd_d  = 1'b1;
                if (hold_full_q) begin
                    load_frame = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    txd_d   = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        // Next bit comes from position 1 before the shift lands.
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (hold_full_q) begin
                        load_frame = 1'b1;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase

        if (load_frame) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            txd_d       = 1'b0;
            state_d     = START;
            baud_d      = '0;
        end

        // ready_q is low whenever hold is full, so accept never overlaps an unload.
        accept = tx_valid && ready_q;
        if (accept) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        ready_d = !hold_full_d;
        busy_d  = (state_d != IDLE) || hold_full_d;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            txd_q       <= 1'b1;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            txd_q       <= txd_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    assign TXD       = txd_q;
    assign tx_ready  = ready_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule
